// File: rtl/cdc_line_echo.sv
// Line-editing echo stage: buffers bytes until CR, then replays the line followed by CR LF.
// Optional build macro CDC_ECHO_UPPERCASE_EN upper-cases a-z on the way out (stored data unchanged).
module cdc_line_echo #(
   parameter int DEPTH = 32,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic [7:0]        rx_data_i,
   input  logic              rx_valid_i,
   output logic              rx_ready_o,
   output logic [7:0]        tx_data_o,
   output logic              tx_valid_o,
   input  logic              tx_ready_i,
   output logic [ADDR_W:0]   line_len_o,
   output logic              busy_o,
   output logic              overflow_o
);

   localparam logic [7:0] CHAR_CR  = 8'h0D;
   localparam logic [7:0] CHAR_LF  = 8'h0A;
   localparam logic [7:0] CHAR_BS  = 8'h08;
   localparam logic [7:0] CHAR_DEL = 8'h7F;
   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W + 1)'(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
      $error("cdc_line_echo: DEPTH must be a power of 2 and >= 2");
   end

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      SEND    = 2'd1,
      SEND_CR = 2'd2,
      SEND_LF = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [ADDR_W:0]     len_reg, len_next;
   logic [ADDR_W-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [7:0]          tx_data_reg, tx_data_next;
   logic                tx_valid_reg, tx_valid_next;
   logic                overflow_reg, overflow_next;

   logic [7:0]          mem [DEPTH];
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   rd_addr;
   logic [7:0]          rd_byte;
   logic                wr_en;
   logic                rx_fire;
   logic                tx_fire;
   logic                last_byte;

   function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef CDC_ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b & 8'hDF;
      end
      return b;
`else
      return b;
`endif
   endfunction

   // Backspace moves the write pointer with the length, so wr_ptr is simply len mod DEPTH.
   assign wr_ptr     = len_reg[ADDR_W-1:0];
   assign rx_ready_o = (state_reg == FILL);
   assign rx_fire    = rx_valid_i && rx_ready_o;
   assign tx_fire    = tx_valid_reg && tx_ready_i;
   assign last_byte  = ({1'b0, rd_ptr_reg} == (len_reg - 1'b1));

   // Address of the byte to present after the next edge: line start on CR, else the following byte.
   assign rd_addr = (state_reg == SEND) ? (rd_ptr_reg + 1'b1) : '0;
   assign rd_byte = mem[rd_addr];

   always_comb begin
      state_next    = state_reg;
      len_next      = len_reg;
      rd_ptr_next   = rd_ptr_reg;
      tx_data_next  = tx_data_reg;
      tx_valid_next = tx_valid_reg;
      overflow_next = 1'b0;
      wr_en         = 1'b0;

      unique case (state_reg)
         FILL: begin
            if (rx_fire) begin
               if (rx_data_i == CHAR_CR) begin
                  tx_valid_next = 1'b1;
                  if (len_reg == '0) begin
                     state_next   = SEND_CR;
                     tx_data_next = CHAR_CR;
                  end else begin
                     state_next   = SEND;
                     rd_ptr_next  = '0;
                     tx_data_next = echo_byte(rd_byte);
                  end
               end else if (rx_data_i == CHAR_LF) begin
                  len_next = len_reg;
               end else if (rx_data_i == CHAR_BS || rx_data_i == CHAR_DEL) begin
                  if (len_reg != '0) begin
                     len_next = len_reg - 1'b1;
                  end
               end else if (len_reg < FULL_LEN) begin
                  wr_en    = 1'b1;
                  len_next = len_reg + 1'b1;
               end else begin
                  overflow_next = 1'b1;
               end
            end
         end
         SEND: begin
            if (tx_fire) begin
               if (last_byte) begin
                  state_next   = SEND_CR;
                  tx_data_next = CHAR_CR;
               end else begin
                  rd_ptr_next  = rd_ptr_reg + 1'b1;
                  tx_data_next = echo_byte(rd_byte);
               end
            end
         end
         SEND_CR: begin
            if (tx_fire) begin
               state_next   = SEND_LF;
               tx_data_next = CHAR_LF;
            end
         end
         SEND_LF: begin
            if (tx_fire) begin
               state_next    = FILL;
               len_next      = '0;
               rd_ptr_next   = '0;
               tx_data_next  = '0;
               tx_valid_next = 1'b0;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg    <= FILL;
         len_reg      <= '0;
         rd_ptr_reg   <= '0;
         tx_data_reg  <= '0;
         tx_valid_reg <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         len_reg      <= len_next;
         rd_ptr_reg   <= rd_ptr_next;
         tx_data_reg  <= tx_data_next;
         tx_valid_reg <= tx_valid_next;
         overflow_reg <= overflow_next;
      end
   end

   // Line storage carries no reset; stale contents are unreachable once len is cleared.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_ptr] <= rx_data_i;
      end
   end

   assign tx_data_o  = tx_data_reg;
   assign tx_valid_o = tx_valid_reg;
   assign line_len_o = len_reg;
   assign busy_o     = (state_reg != FILL);
   assign overflow_o = overflow_reg;

endmodule

// File: tb/tb_cdc_line_echo.sv
// Directed bench for cdc_line_echo: a DEPTH=32 and a DEPTH=4 instance share stimulus;
// a select picks which one is observed. Table vectors plus hand-written corner sequences.
module tb_cdc_line_echo;

   logic       clk;
   logic       rstn;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_ready;

   logic       a_rx_ready, a_tx_valid, a_busy, a_ovf;
   logic [7:0] a_tx_data;
   logic [5:0] a_len;
   logic       b_rx_ready, b_tx_valid, b_busy, b_ovf;
   logic [7:0] b_tx_data;
   logic [2:0] b_len;

   logic       s_rx_ready, s_tx_valid, s_busy, s_ovf;
   logic [7:0] s_tx_data;
   logic [5:0] s_len;
   int         sel;

   int checks;
   int errors;
   int ovf_cnt;
   int peak;

   typedef struct {
      int    sel;
      int    tog;
      string rx;
      string ex;
      int    ovf;
      int    peak;
   } vec_t;

   vec_t vecs[8];

   cdc_line_echo #(.DEPTH(32)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(a_rx_ready),
      .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid), .tx_ready_i(tx_ready),
      .line_len_o(a_len), .busy_o(a_busy), .overflow_o(a_ovf)
   );

   cdc_line_echo #(.DEPTH(4)) dut4 (
      .clk_i(clk), .rstn_i(rstn),
      .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(b_rx_ready),
      .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid), .tx_ready_i(tx_ready),
      .line_len_o(b_len), .busy_o(b_busy), .overflow_o(b_ovf)
   );

   always_comb begin
      s_rx_ready = (sel == 1) ? b_rx_ready : a_rx_ready;
      s_tx_valid = (sel == 1) ? b_tx_valid : a_tx_valid;
      s_tx_data  = (sel == 1) ? b_tx_data  : a_tx_data;
      s_busy     = (sel == 1) ? b_busy     : a_busy;
      s_ovf      = (sel == 1) ? b_ovf      : a_ovf;
      s_len      = (sel == 1) ? {3'b000, b_len} : a_len;
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] up(input logic [7:0] b);
`ifdef CDC_ECHO_UPPERCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) begin
         return b & 8'hDF;
      end
`endif
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rstn     = 1'b0;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Offer one byte, wait (bounded) for rx_ready, return at #1 after the accepting edge.
   task automatic put_byte(input logic [7:0] b);
      int t;
      t        = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!s_rx_ready && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 200) begin
         check("rx_ready timeout", 32'(t), 32'd0);
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      if (s_ovf) ovf_cnt++;
      if (int'(s_len) > peak) peak = int'(s_len);
      $display("rx byte 0x%02h len=%0d overflow=%0b", b, s_len, s_ovf);
   endtask

   task automatic put_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         put_byte(s[i]);
      end
   endtask

   // Collect the echoed bytes; tog=1 drives tx_ready 1,0,1,0... and checks hold stability.
   task automatic collect(input string ex, input int tog);
      int         got;
      int         cyc;
      int         phase;
      logic       hold_pending;
      logic [7:0] held;
      got          = 0;
      cyc          = 0;
      phase        = 0;
      hold_pending = 1'b0;
      held         = '0;
      while (got < ex.len() && cyc < 200) begin
         tx_ready = (tog != 0) ? ((phase % 2) == 0) : 1'b1;
         phase++;
         check("rx_ready low while sending", 32'(s_rx_ready), 32'd0);
         if (hold_pending) begin
            check("tx_valid held", 32'(s_tx_valid), 32'd1);
            check("tx_data held", 32'(s_tx_data), 32'(held));
         end
         hold_pending = 1'b0;
         if (s_tx_valid && tx_ready) begin
            check($sformatf("tx byte %0d", got), 32'(s_tx_data), 32'(up(ex[got])));
            $display("tx byte %0d data 0x%02h", got, s_tx_data);
            got++;
         end else if (s_tx_valid) begin
            held         = s_tx_data;
            hold_pending = 1'b1;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      tx_ready = 1'b1;
      if (got < ex.len()) begin
         check("tx byte count (timeout)", 32'(got), 32'(ex.len()));
      end
      if (tog == 0) begin
         check("tx cycles at 1 byte/cycle", 32'(cyc), 32'(ex.len()));
      end
      check("tx_valid low after LF", 32'(s_tx_valid), 32'd0);
      check("rx_ready high after LF", 32'(s_rx_ready), 32'd1);
      check("busy low after LF", 32'(s_busy), 32'd0);
      check("line_len 0 after LF", 32'(s_len), 32'd0);
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      sel      = 0;
      rstn     = 1'b0;
      rx_valid = 1'b0;
      rx_data  = '0;
      tx_ready = 1'b1;
      ovf_cnt  = 0;
      peak     = 0;

      vecs[0] = '{sel: 0, tog: 0, rx: "ab\015",         ex: "ab\015\012",   ovf: 0, peak: 2};
      vecs[1] = '{sel: 0, tog: 1, rx: "xyz\015",        ex: "xyz\015\012",  ovf: 0, peak: 3};
      vecs[2] = '{sel: 1, tog: 0, rx: "abcdef\015",     ex: "abcd\015\012", ovf: 2, peak: 4};
      vecs[3] = '{sel: 0, tog: 0, rx: "\010ab\177c\015", ex: "ac\015\012",  ovf: 0, peak: 2};
      vecs[4] = '{sel: 0, tog: 0, rx: "\015",           ex: "\015\012",     ovf: 0, peak: 0};
      vecs[5] = '{sel: 0, tog: 0, rx: "aZ1q\015",       ex: "aZ1q\015\012", ovf: 0, peak: 4};
      vecs[6] = '{sel: 0, tog: 0, rx: "a\012b\015",     ex: "ab\015\012",   ovf: 0, peak: 2};
      vecs[7] = '{sel: 1, tog: 1, rx: "wxyz\015",       ex: "wxyz\015\012", ovf: 0, peak: 4};

      // Reset values while rstn is held low
      #3;
      check("reset rx_ready", 32'(a_rx_ready), 32'd1);
      check("reset tx_valid", 32'(a_tx_valid), 32'd0);
      check("reset tx_data", 32'(a_tx_data), 32'd0);
      check("reset line_len", 32'(a_len), 32'd0);
      check("reset busy", 32'(a_busy), 32'd0);
      check("reset overflow", 32'(a_ovf), 32'd0);

      // Latency and back-pressure on rx around the CR
      do_reset();
      sel = 0;
      put_byte(8'h61);
      put_byte(8'h62);
      check("t1 tx_valid before CR", 32'(s_tx_valid), 32'd0);
      check("t1 line_len before CR", 32'(s_len), 32'd2);
      put_byte(8'h0D);
      check("t1 tx_valid 1 cycle after CR", 32'(s_tx_valid), 32'd1);
      check("t1 first tx byte", 32'(s_tx_data), 32'(up(8'h61)));
      check("t1 busy after CR", 32'(s_busy), 32'd1);
      collect("ab\015\012", 0);

      for (int v = 0; v < 8; v++) begin
         do_reset();
         sel     = vecs[v].sel;
         ovf_cnt = 0;
         peak    = 0;
         put_str(vecs[v].rx);
         collect(vecs[v].ex, vecs[v].tog);
         check($sformatf("vec %0d overflow pulses", v), 32'(ovf_cnt), 32'(vecs[v].ovf));
         check($sformatf("vec %0d peak line_len", v), 32'(peak), 32'(vecs[v].peak));
      end

      // Reset asserted mid-send aborts immediately, then the stage works again
      do_reset();
      sel = 0;
      put_str("hello\015");
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check("abort tx_valid", 32'(s_tx_valid), 32'd0);
      check("abort busy", 32'(s_busy), 32'd0);
      check("abort line_len", 32'(s_len), 32'd0);
      check("abort rx_ready", 32'(s_rx_ready), 32'd1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      put_str("hi\015");
      collect("hi\015\012", 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
